// File: rtl/ifft_cp_insert_pkg.sv
// Shared types, sizing constants and the sample reduction helper for the
// cyclic-prefix inserter.
package ifft_cp_insert_pkg;

  localparam int unsigned OUT_W   = 16;
  localparam int unsigned MAX_PTS = 2048;
  localparam int unsigned AW      = $clog2(MAX_PTS);
  localparam int unsigned CNT_W   = 12;

  typedef enum logic [1:0] {
    StFill,
    StCp,
    StBody
  } state_e;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
  } beat_t;

  // Round half up, arithmetic shift, then clamp to a signed out_w-bit range.
  function automatic logic [OUT_W-1:0] sat_round(input logic signed [63:0] x,
                                                 input int unsigned shift,
                                                 input int unsigned out_w);
    logic signed [63:0] rnd;
    logic signed [63:0] y;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
    y   = (x + rnd) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    if (y > hi) begin
      y = hi;
    end else if (y < lo) begin
      y = lo;
    end
    return OUT_W'(y);
  endfunction

endpackage

// File: rtl/ifft_cp_insert_if.sv
// Avalon-ST style sample stream: handshake, framing, error code and I/Q data.
interface ifft_cp_insert_if #(
  parameter int unsigned W = 32
) ();
  logic                valid;
  logic                ready;
  logic                sop;
  logic                eop;
  logic [1:0]          error;
  logic signed [W-1:0] re;
  logic signed [W-1:0] im;

  modport master (output valid, sop, eop, error, re, im, input ready);
  modport slave  (input valid, sop, eop, error, re, im, output ready);
endinterface

// File: rtl/ifft_cp_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module ifft_cp_ram #(
  parameter int unsigned Depth = 2048,
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 11
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifft_cp_insert.sv
// Buffers one IFFT output frame at reduced precision and replays it with a
// cyclic prefix (last C samples, then all N samples).
module ifft_cp_insert
  import ifft_cp_insert_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  ifft_cp_insert_if.slave  sink,
  input  logic [CNT_W-1:0] fftpts_in,
  input  logic [CNT_W-1:0] cp_len,
  ifft_cp_insert_if.master source,
  output logic             proto_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       err_acc_q, err_acc_d;
  logic [1:0]       out_err_q, out_err_d;
  logic             active_q, active_d;
  logic             bad_q, bad_d;
  logic             body_done_q, body_done_d;
  logic             proto_err_q, proto_err_d;

  logic             pend_q, pend_sop_q, pend_eop_q;
  beat_t            fifo_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       fifo_cnt_q;
  beat_t            head;

  logic signed [IN_W-1:0] in_re, in_im;
  logic [OUT_W-1:0]       wr_re, wr_im;
  logic [2*OUT_W-1:0]     rdata;
  logic                   accept, pop, room, out_valid;
  logic [2:0]             occ;
  logic                   we, issue, tag_sop, tag_eop, take;
  logic [AW-1:0]          waddr, raddr;
  logic [CNT_W-1:0]       n_eff, c_eff, idx;
  logic [1:0]             err_eff;
  logic                   bad_eff;

  assign in_re = sink.re;
  assign in_im = sink.im;
  assign wr_re = sat_round(64'(in_re), SHIFT, OUT_W);
  assign wr_im = sat_round(64'(in_im), SHIFT, OUT_W);

  assign sink.ready = (state_q == StFill);
  assign accept     = sink.valid && sink.ready;

  assign head      = fifo_q[rptr_q];
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && source.ready;

  // Occupancy after this cycle, counting the read already in the RAM stage.
  assign occ  = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign room = (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    n_d         = n_q;
    c_d         = c_q;
    rd_cnt_d    = rd_cnt_q;
    err_acc_d   = err_acc_q;
    out_err_d   = out_err_q;
    active_d    = active_q;
    bad_d       = bad_q;
    body_done_d = body_done_q;
    proto_err_d = proto_err_q;
    we          = 1'b0;
    waddr       = '0;
    issue       = 1'b0;
    raddr       = '0;
    tag_sop     = 1'b0;
    tag_eop     = 1'b0;
    take        = 1'b0;
    n_eff       = n_q;
    c_eff       = c_q;
    err_eff     = err_acc_q;
    bad_eff     = bad_q;
    idx         = wr_cnt_q;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (sink.sop) begin
            // A sop always (re)starts the frame, even mid-frame.
            proto_err_d = proto_err_q | active_q;
            n_eff       = fftpts_in;
            c_eff       = cp_len;
            err_eff     = sink.error;
            bad_eff     = (fftpts_in == '0) || (cp_len >= fftpts_in) ||
                          (fftpts_in > CNT_W'(MAX_PTS));
            idx         = '0;
            take        = 1'b1;
          end else begin
            err_eff = err_acc_q | sink.error;
            take    = active_q;
            if (!active_q) begin
              proto_err_d = 1'b1;
            end
          end
          if (take) begin
            we        = 1'b1;
            waddr     = AW'(idx);
            n_d       = n_eff;
            c_d       = c_eff;
            err_acc_d = err_eff;
            bad_d     = bad_eff;
            wr_cnt_d  = idx + CNT_W'(1);
            active_d  = 1'b1;
            if (sink.eop) begin
              active_d = 1'b0;
              wr_cnt_d = '0;
              if (bad_eff || (idx + CNT_W'(1) != n_eff)) begin
                proto_err_d = 1'b1;
              end else begin
                state_d     = (c_eff == '0) ? StBody : StCp;
                rd_cnt_d    = '0;
                body_done_d = 1'b0;
                out_err_d   = err_eff;
              end
            end
          end
        end
      end
      StCp: begin
        if (room) begin
          issue   = 1'b1;
          raddr   = AW'(n_q - c_q + rd_cnt_q);
          tag_sop = (rd_cnt_q == '0);
          if (rd_cnt_q == c_q - CNT_W'(1)) begin
            state_d  = StBody;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      StBody: begin
        if (!body_done_q && room) begin
          issue   = 1'b1;
          raddr   = AW'(rd_cnt_q);
          tag_sop = (c_q == '0) && (rd_cnt_q == '0);
          tag_eop = (rd_cnt_q == n_q - CNT_W'(1));
          if (tag_eop) begin
            body_done_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
        // Input reopens only once the final beat has left the block.
        if (pop && head.eop) begin
          state_d     = StFill;
          body_done_d = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFill;
      wr_cnt_q    <= '0;
      n_q         <= '0;
      c_q         <= '0;
      rd_cnt_q    <= '0;
      err_acc_q   <= '0;
      out_err_q   <= '0;
      active_q    <= 1'b0;
      bad_q       <= 1'b0;
      body_done_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      n_q         <= n_d;
      c_q         <= c_d;
      rd_cnt_q    <= rd_cnt_d;
      err_acc_q   <= err_acc_d;
      out_err_q   <= out_err_d;
      active_q    <= active_d;
      bad_q       <= bad_d;
      body_done_q <= body_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      pend_sop_q <= 1'b0;
      pend_eop_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      pend_q <= issue;
      if (issue) begin
        pend_sop_q <= tag_sop;
        pend_eop_q <= tag_eop;
      end
      if (pend_q) begin
        fifo_q[wptr_q] <= {pend_sop_q, pend_eop_q, rdata};
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

  ifft_cp_ram #(
    .Depth (MAX_PTS),
    .Width (2 * OUT_W),
    .AddrW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i ({wr_re, wr_im}),
    .re_i    (issue),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign source.valid = out_valid;
  assign source.sop   = out_valid & head.sop;
  assign source.eop   = out_valid & head.eop;
  assign source.re    = head.re;
  assign source.im    = head.im;
  assign source.error = out_err_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ifft_cp_insert.sv
// Directed scoreboard bench for the cyclic-prefix inserter.
module tb_ifft_cp_insert;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] fftpts;
  logic [11:0] cp;
  logic        proto_err;

  ifft_cp_insert_if #(.W(32)) snk ();
  ifft_cp_insert_if #(.W(16)) src ();

  ifft_cp_insert #(
    .IN_W  (32),
    .SHIFT (8)
  ) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .sink      (snk),
    .fftpts_in (fftpts),
    .cp_len    (cp),
    .source    (src),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  string       req_name[$];
  logic [63:0] req_act[$];
  logic [63:0] req_exp[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          eop_cyc = 0;
  bit          lat_arm = 1'b0;
  bit          lat_done = 1'b0;
  bit          bp = 1'b0;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int          ph = 0;
  logic [31:0] stim_re[32];
  logic [31:0] stim_im[32];
  logic [15:0] exp_re[32];
  logic [15:0] exp_im[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic req(input string name, input logic [63:0] act, input logic [63:0] exp);
    req_name.push_back(name);
    req_act.push_back(act);
    req_exp.push_back(exp);
  endtask

  // Monitor: the only process that compares and counts.
  bit          stall_q = 1'b0;
  bit          last_eop = 1'b0;
  logic [36:0] held;
  always @(negedge clk) begin
    logic [36:0] cur;
    exp_t        e;
    while (req_name.size() != 0) check(req_name.pop_front(), req_act.pop_front(),
                                       req_exp.pop_front());
    cur = {src.valid, src.sop, src.eop, src.error, src.re, src.im};
    if (!rst_n) begin
      stall_q  = 1'b0;
      last_eop = 1'b0;
    end else begin
      if (stall_q) check("stall_hold", 64'(cur), 64'(held));
      if (last_eop) check("sink_ready_after_eop", 64'(snk.ready), 64'd1);
      last_eop = 1'b0;
      if (lat_arm && !lat_done && src.valid) begin
        check("first_valid_latency", 64'(cyc - eop_cyc), 64'd2);
        lat_done = 1'b1;
      end
      if (src.valid && src.ready) begin
        check("sink_ready_busy", 64'(snk.ready), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: actual %0h required no output", cur);
        end else begin
          e = sb.pop_front();
          check("beat", 64'(cur[35:0]), 64'(e));
        end
        last_eop = src.eop;
      end
      stall_q = src.valid && !src.ready;
      held    = cur;
    end
  end

  initial begin
    src.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        src.ready = pat[ph];
        ph        = (ph + 1) % 4;
      end else begin
        src.ready = 1'b1;
        ph        = 0;
      end
    end
  end

  task automatic ramp(input int n);
    for (int k = 0; k < n; k++) begin
      stim_re[k] = 32'(k) << 8;
      stim_im[k] = -(32'(k) << 8);
      exp_re[k]  = 16'(k);
      exp_im[k]  = -16'(k);
    end
  endtask

  task automatic send_frame(input int npts, input int cpl, input int nbeats, input int err_beat,
                            input logic [1:0] err_code, input bit push);
    exp_t       e;
    logic [1:0] ecode;
    bit         acc;
    ecode = (err_beat >= 0) ? err_code : 2'b00;
    if (push) begin
      for (int j = 0; j < cpl; j++) begin
        e = '{sop: (j == 0), eop: 1'b0, err: ecode, re: exp_re[npts-cpl+j],
              im: exp_im[npts-cpl+j]};
        sb.push_back(e);
      end
      for (int k = 0; k < npts; k++) begin
        e = '{sop: (cpl == 0 && k == 0), eop: (k == npts - 1), err: ecode, re: exp_re[k],
              im: exp_im[k]};
        sb.push_back(e);
      end
    end
    for (int b = 0; b < nbeats; b++) begin
      snk.valid = 1'b1;
      snk.sop   = (b == 0);
      snk.eop   = (b == nbeats - 1);
      snk.error = (b == err_beat) ? err_code : 2'b00;
      snk.re    = stim_re[b];
      snk.im    = stim_im[b];
      fftpts    = 12'(npts);
      cp        = 12'(cpl);
      acc       = 1'b0;
      for (int t = 0; t < 1000 && !acc; t++) begin
        @(negedge clk);
        acc = snk.ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        req("sink_accept", 64'd0, 64'd1);
        break;
      end
      if (b == nbeats - 1) eop_cyc = cyc;
    end
    snk.valid = 1'b0;
    snk.sop   = 1'b0;
    snk.eop   = 1'b0;
    snk.error = 2'b00;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    req("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic reset_checks();
    req("rst_sink_ready", 64'(snk.ready), 64'd1);
    req("rst_valid", 64'(src.valid), 64'd0);
    req("rst_sop", 64'(src.sop), 64'd0);
    req("rst_eop", 64'(src.eop), 64'd0);
    req("rst_real", 64'(src.re), 64'd0);
    req("rst_imag", 64'(src.im), 64'd0);
    req("rst_error", 64'(src.error), 64'd0);
    req("rst_proto_err", 64'(proto_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    snk.valid = 1'b0;
    snk.sop   = 1'b0;
    snk.eop   = 1'b0;
    snk.error = 2'b00;
    snk.re    = '0;
    snk.im    = '0;
    fftpts    = '0;
    cp        = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame with prefix, full throughput, latency measured.
    ramp(16);
    lat_arm = 1'b1;
    send_frame(16, 4, 16, -1, 2'b00, 1'b1);
    wait_drain();

    // Rounding and saturation corners.
    stim_re[0] = 32'h0000_0080; exp_re[0] = 16'd1;
    stim_re[1] = 32'h0000_007F; exp_re[1] = 16'd0;
    stim_re[2] = 32'h7FFF_FFFF; exp_re[2] = 16'h7FFF;
    stim_re[3] = 32'h8000_0000; exp_re[3] = 16'h8000;
    stim_re[4] = 32'hFFFF_FF80; exp_re[4] = 16'd0;
    for (int k = 0; k < 5; k++) begin
      stim_im[k] = '0;
      exp_im[k]  = '0;
    end
    send_frame(5, 0, 5, -1, 2'b00, 1'b1);
    wait_drain();

    // Downstream backpressure.
    ramp(8);
    bp = 1'b1;
    send_frame(8, 2, 8, -1, 2'b00, 1'b1);
    wait_drain();
    bp = 1'b0;
    req("proto_err_clean", 64'(proto_err), 64'd0);

    // Short frame is discarded and flagged; a good frame follows.
    send_frame(8, 0, 6, -1, 2'b00, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    req("proto_err_short", 64'(proto_err), 64'd1);
    send_frame(8, 0, 8, -1, 2'b00, 1'b1);
    wait_drain();

    // Error code propagation, then a clean frame.
    ramp(16);
    send_frame(16, 4, 16, 3, 2'b01, 1'b1);
    wait_drain();
    send_frame(16, 4, 16, -1, 2'b00, 1'b1);
    wait_drain();

    // Reset while replaying the prefix.
    send_frame(16, 4, 16, -1, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4, 1, 4, -1, 2'b00, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
